ps2_host_receiver: RTL and testbench

//  Host-side PS/2 receiver: deserialises device-to-host frames (mouse replies, ACK 0xFA, stream packets).

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_host_receiver.sv | 150 +++++++++++++++
 tb/tb_ps2_host_receiver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame length, error codes, receiver state encoding
// and the mouse acknowledge byte.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] ACK_BYTE = 8'hFA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01,
    ST_STOP = 2'b10
  } rx_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus level filter for a slow, noisy open-collector line.
// The filtered level only moves after FILTER_LEN consecutive synchronised
// samples disagree with it; a 1->0 move produces a one-cycle fall pulse.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Metastability chain; resets to the idle-high bus level so release from
  // reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], line};
  end

  // Count consecutive disagreeing samples; commit the new level on the
  // FILTER_LEN-th one and flag a falling transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync_s;
        cnt   <= '0;
        fall  <= ~sync_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_receiver.sv
// Host-side PS/2 receiver: deserialises device-to-host frames
// (start 0, 8 data LSB-first, odd parity, stop 1) sampled on filtered
// PS2CLK falling edges. Read-only on the bus.
// Handshake: rx_valid / rx_err are single-cycle pulses with no back-pressure;
// rx_data and rx_err_code are meaningful in the cycle of their pulse, and
// rx_data holds the last good byte otherwise.
module ps2_host_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_en,
  input  logic       PS2CLK,
  input  logic       PS2DATA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic       rx_busy,
  output logic [1:0] rx_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  rx_state_t              state, state_n;
  logic [7:0]             shreg, shreg_n;
  logic                   par, par_n;
  logic [3:0]             bitcnt, bitcnt_n;
  logic [TW-1:0]          timer, timer_n;
  logic [7:0]             data_n;
  logic                   valid_n, err_n;
  logic [1:0]             code_n;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   data_s;
  logic                   clk_fall;
  logic                   unused_clk_level;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk  (CLK),
    .rst_n(RST),
    .line (PS2CLK),
    .level(unused_clk_level),
    .fall (clk_fall)
  );

  // PS2DATA only needs the synchroniser: it is sampled on clock falls, long
  // after it settled during the clock-high phase.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) data_sync <= '1;
    else      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2DATA};
  end

  assign data_s   = data_sync[SYNC_STAGES-1];
  assign rx_busy  = (state != ST_IDLE);
  assign rx_state = state;

  // Next-state and output decode; rx_en loss beats a fall, a fall beats timeout.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    par_n    = par;
    bitcnt_n = bitcnt;
    timer_n  = timer;
    data_n   = rx_data;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    code_n   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (clk_fall && rx_en && !data_s) begin
          state_n  = ST_RECV;
          bitcnt_n = '0;
          shreg_n  = '0;
          par_n    = 1'b0;
        end
      end
      ST_RECV, ST_STOP: begin
        if (!rx_en) begin
          state_n = ST_IDLE;
          timer_n = '0;
        end else if (clk_fall) begin
          timer_n = '0;
          if (state == ST_RECV) begin
            if (bitcnt == 4'd8) begin
              par_n   = data_s;
              state_n = ST_STOP;
            end else begin
              shreg_n = {data_s, shreg[7:1]};
            end
            bitcnt_n = bitcnt + 4'd1;
          end else begin
            state_n = ST_IDLE;
            if (!(^{shreg, par})) begin
              err_n  = 1'b1;
              code_n = ERR_PARITY;
            end else if (!data_s) begin
              err_n  = 1'b1;
              code_n = ERR_STOP;
            end else begin
              valid_n = 1'b1;
              data_n  = shreg;
            end
          end
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state_n = ST_IDLE;
          timer_n = '0;
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
        end else if (timer != TW'(TIMEOUT_CYC)) begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      par         <= 1'b0;
      bitcnt      <= '0;
      timer       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= ERR_NONE;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      par         <= par_n;
      bitcnt      <= bitcnt_n;
      timer       <= timer_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      rx_err      <= err_n;
      rx_err_code <= code_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_receiver.sv
// Bench for ps2_host_receiver: device-side PS/2 model drives frames, a
// scoreboard queue holds expected {is_err, code, data} events and a monitor
// pops and compares on every rx_valid / rx_err pulse. The PS/2 clock is
// scaled (half period HP system cycles) and TIMEOUT_CYC reduced to keep the
// run short.
module tb_ps2_host_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 600;
  localparam int HP          = 20;
  localparam int W           = 11;

  localparam logic [1:0] C_PAR  = 2'b01;
  localparam logic [1:0] C_STOP = 2'b10;
  localparam logic [1:0] C_TMO  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       rx_busy;
  logic [1:0] rx_state;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_fall = 0;
  logic [7:0]   model_last = 8'h00;
  logic [7:0]   prev_data = 8'h00;

  ps2_host_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .rx_en      (rx_en),
    .PS2CLK     (ps2clk),
    .PS2DATA    (ps2data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .rx_err_code(rx_err_code),
    .rx_busy    (rx_busy),
    .rx_state   (rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model ----------------
  // Outcome of a complete frame from the protocol rules: odd parity over
  // data+parity bit, then stop bit must be 1; parity error has priority.
  function automatic logic [W-1:0] frame_outcome(input logic [7:0] b,
                                                 input logic par,
                                                 input logic stop);
    int ones;
    ones = $countones(b) + int'(par);
    if (ones % 2 == 0) return {1'b1, C_PAR, 8'h00};
    if (!stop)         return {1'b1, C_STOP, 8'h00};
    return {1'b0, 2'b00, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One device bit: data set during clock-high, then a low phase.
  task automatic ps2_bit(input logic b);
    ps2data = b;
    repeat (HP) @(posedge clk);
    #1 ps2clk = 1'b0;
    last_fall = cyc;
    repeat (HP) @(posedge clk);
    #1 ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic par;
    par = ~(^b) ^ bad_par;
    exp_q.push_back(frame_outcome(b, par, stop));
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2data = 1'b1;
  endtask

  // Start bit plus the first n data bits, then the device goes quiet.
  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
    ps2data = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s_drain: timed out, %0d events outstanding busy=%0b", name, exp_q.size(), rx_busy);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_busy_low"}, {31'd0, rx_busy}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (!rst_n) begin
      prev_data = 8'h00;
    end else begin
      if (rx_valid && rx_err) begin
        n_fail++;
        $display("FAIL valid_and_err: both high at cycle %0d", cyc);
      end
      if (!rx_err && rx_err_code != 2'b00) begin
        n_fail++;
        $display("FAIL code_idle: got %0b expected 00", rx_err_code);
      end
      if (!rx_valid && rx_data != prev_data) begin
        n_fail++;
        $display("FAIL data_hold: got %0h expected %0h", rx_data, prev_data);
      end
      prev_data = rx_data;
      if (rx_valid || rx_err) begin
        got = rx_err ? {1'b1, rx_err_code, 8'h00} : {1'b0, 2'b00, rx_data};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL event: got %0h expected %0h", got, exp);
          end
          if (!exp[W-1]) model_last = exp[7:0];
        end
        if (rx_err) begin
          n_vec++;
          if (rx_data !== model_last) begin
            n_fail++;
            $display("FAIL err_data_kept: got %0h expected %0h", rx_data, model_last);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    logic seen_busy;

    repeat (5) @(posedge clk);
    #1;
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_err", {31'd0, rx_err}, 32'd0);
    check("rst_code", {30'd0, rx_err_code}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_state", {30'd0, rx_state}, 32'd0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // ACK byte
    send_frame(8'hFA, 1'b0, 1'b1);
    wait_idle("ack");
    check("ack_data", {24'd0, rx_data}, 32'h0000_00FA);

    // back-to-back
    send_frame(8'h08, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_idle("b2b");

    // parity error, data holds
    send_frame(8'hFA, 1'b1, 1'b1);
    wait_idle("parity");
    check("parity_hold", {24'd0, rx_data}, 32'h0000_00FF);

    // stop bit error
    send_frame(8'h55, 1'b0, 1'b0);
    wait_idle("stop");

    // timeout after 4 data bits
    exp_q.push_back({1'b1, C_TMO, 8'h00});
    send_partial(8'hA5, 4);
    n = 0;
    while (!rx_err && n < TIMEOUT_CYC + 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = cyc - last_fall;
    n_vec++;
    if (!rx_err || lat < TIMEOUT_CYC + SYNC_STAGES + FILTER_LEN ||
        lat > TIMEOUT_CYC + SYNC_STAGES + FILTER_LEN + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles (err=%0b) expected %0d", lat, rx_err,
               TIMEOUT_CYC + SYNC_STAGES + FILTER_LEN + 1);
    end
    wait_idle("timeout");

    // short glitch on idle clock, with data low so a real fall would start a frame
    ps2data = 1'b0;
    ps2clk  = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2clk = 1'b1;
    ps2data = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rx_busy) seen_busy = 1'b1;
    end
    check("glitch_no_start", {31'd0, seen_busy}, 32'd0);

    // rx_en drop mid-frame
    send_partial(8'h55, 4);
    check("en_busy_before", {31'd0, rx_busy}, 32'd1);
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    check("en_abort_busy", {31'd0, rx_busy}, 32'd0);
    repeat (20) @(posedge clk);
    #1 rx_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send_frame(8'h08, 1'b0, 1'b1);
    wait_idle("en_recover");

    // reset mid-frame
    send_partial(8'h3C, 3);
    check("rst_mid_busy_before", {31'd0, rx_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", {24'd0, rx_data}, 32'd0);
    check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    model_last = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    send_frame(8'hFA, 1'b0, 1'b1);
    wait_idle("rst_recover");

    // randomized frames with occasional parity / stop corruption
    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0));
    end
    wait_idle("random");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global bound on the run.
  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1);
  end

endmodule
